// File: rtl/uart_tx_cfg_if.sv
// Byte handshake between a producer and the UART transmitter.
//   valid   : producer offers data_in for transmission
//   data_in : payload word, DATA_BITS wide, sent LSB first
//   ready   : transmitter holding register is empty
// master = producer side, slave = transmitter side.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid;
    logic [DATA_BITS-1:0] data_in;
    logic                 ready;

    modport master (output valid, output data_in, input ready);
    modport slave  (input valid, input data_in, output ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-word holding register in front of
// the frame shifter, so a producer can queue the next word while the current
// frame is on the line (back-to-back frames with no idle bits).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   tick : one-clk baud strobe, one per bit period, free-running
//   bus  : valid/data_in/ready handshake (slave side)
//   tx   : registered serial line, idle high
//   busy : frame state machine not idle
//   done : one-clk pulse after the final stop bit of a frame
module uart_tx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    uart_tx_cfg_if.slave  bus,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be within 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_reg,     state_next;
    logic                 tx_reg,        tx_next;
    logic [DATA_BITS-1:0] frame_reg,     frame_next;
    logic [DATA_BITS-1:0] hold_reg,      hold_next;
    logic                 hold_full_reg, hold_full_next;
    logic [CNT_W-1:0]     bit_cnt_reg,   bit_cnt_next;
    logic                 stop_cnt_reg,  stop_cnt_next;
    logic                 done_reg,      done_next;

    logic [CNT_W-1:0]     next_idx;
    logic                 parity_bit;

    // The frame register keeps the captured payload intact for the whole
    // frame (bits are picked by index rather than shifted out), so parity is
    // always taken from the word being sent, never from live data_in.
    assign next_idx   = bit_cnt_reg + CNT_W'(1);
    assign parity_bit = (^frame_reg) ^ (PARITY == 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            tx_reg        <= 1'b1;
            frame_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tx_reg        <= tx_next;
            frame_reg     <= frame_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            bit_cnt_reg   <= bit_cnt_next;
            stop_cnt_reg  <= stop_cnt_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tx_next        = tx_reg;
        frame_next     = frame_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        bit_cnt_next   = bit_cnt_reg;
        stop_cnt_next  = stop_cnt_reg;
        done_next      = 1'b0;

        // Accept and reload are mutually exclusive: accept needs an empty
        // holding register, reload needs a full one. A word accepted on a
        // tick edge therefore waits for the following tick to start.
        if (bus.valid && !hold_full_reg) begin
            hold_next      = bus.data_in;
            hold_full_next = 1'b1;
        end

        if (tick) begin
            case (state_reg)
                S_IDLE: begin
                    tx_next = 1'b1;
                    if (hold_full_reg) begin
                        frame_next     = hold_reg;
                        hold_full_next = 1'b0;
                        tx_next        = 1'b0;
                        state_next     = S_START;
                    end
                end
                S_START: begin
                    tx_next      = frame_reg[0];
                    bit_cnt_next = '0;
                    state_next   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            tx_next    = parity_bit;
                            state_next = S_PARITY;
                        end else begin
                            tx_next       = 1'b1;
                            stop_cnt_next = 1'b0;
                            state_next    = S_STOP;
                        end
                    end else begin
                        bit_cnt_next = next_idx;
                        tx_next      = frame_reg[next_idx];
                    end
                end
                S_PARITY: begin
                    tx_next       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = S_STOP;
                end
                S_STOP: begin
                    if (stop_cnt_reg == 1'(STOP_BITS - 1)) begin
                        done_next = 1'b1;
                        // A queued word follows immediately: the tick that
                        // ends the last stop bit also begins the next start bit.
                        if (hold_full_reg) begin
                            frame_next     = hold_reg;
                            hold_full_next = 1'b0;
                            tx_next        = 1'b0;
                            state_next     = S_START;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    tx_next    = 1'b1;
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = !hold_full_reg;
    assign tx        = tx_reg;
    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    always #5 clk = ~clk;

    // Four configurations: default, even parity, odd parity, 7 data + 2 stop.
    uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();
    logic tx0, tx1, tx2, tx3, busy0, busy1, busy2, busy3, done0, done1, done2, done3;

    uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .bus(if0.slave), .tx(tx0), .busy(busy0), .done(done0));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .bus(if1.slave), .tx(tx1), .busy(busy1), .done(done1));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .bus(if2.slave), .tx(tx2), .busy(busy2), .done(done2));
    uart_tx_cfg #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .tick(tick), .bus(if3.slave), .tx(tx3), .busy(busy3), .done(done3));

    // Baud strobe every 16 clk, changed on the falling edge.
    int phase = 0;
    always @(negedge clk) begin
        phase = (phase == 15) ? 0 : phase + 1;
        tick  = (phase == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sel = 0;
    int checks = 0;
    int errors = 0;

    function automatic logic tx_of(int s);
        case (s) 0: return tx0; 1: return tx1; 2: return tx2; default: return tx3; endcase
    endfunction
    function automatic logic busy_of(int s);
        case (s) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
    endfunction
    function automatic logic done_of(int s);
        case (s) 0: return done0; 1: return done1; 2: return done2; default: return done3; endcase
    endfunction
    function automatic logic ready_of(int s);
        case (s) 0: return if0.ready; 1: return if1.ready; 2: return if2.ready; default: return if3.ready; endcase
    endfunction

    // ---------------- scoreboard + line monitor ----------------
    typedef struct {
        string bits;      // expected line levels, one char per bit period
        string name;
        bit    may_abort; // frame is expected to be cut short by reset
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   mon_active = 1'b0;
    int   mon_phase  = 0;
    int   mon_idx    = 0;
    int   mon_bad    = 0;
    int   start_q[$];
    int   done_seen  = 0;
    int   done_cyc   = 0;
    int   busy_cycles = 0;

    always @(negedge clk) begin
        logic t;
        logic eb;
        t = tx_of(sel);
        if (done_of(sel)) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (busy_of(sel)) busy_cycles++;
        if (rst) begin
            if (mon_active) begin
                checks++;
                if (!cur.may_abort) begin
                    errors++;
                    $display("FAIL %s: frame cut by reset at bit %0d, required complete frame", cur.name, mon_idx);
                end else begin
                    $display("frame %s: abandoned by reset after %0d bits", cur.name, mon_idx);
                end
                mon_active = 1'b0;
            end
        end else if (!mon_active) begin
            if (t == 1'b0) begin
                start_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required idle line", cyc);
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_phase  = 0;
                    mon_idx    = 0;
                    mon_bad    = 0;
                end
            end
        end else begin
            mon_phase++;
            // Sample each bit in the middle of its 16-clk period.
            if (mon_phase == 16 * mon_idx + 8) begin
                eb = (cur.bits[mon_idx] == 8'h31);
                checks++;
                if (t !== eb) begin
                    errors++;
                    mon_bad++;
                    $display("FAIL %s bit%0d: tx=%b, required %b", cur.name, mon_idx, t, eb);
                end
                mon_idx++;
                if (mon_idx == cur.bits.len()) begin
                    mon_active = 1'b0;
                    $display("frame %s: %0d bits compared, %0d wrong", cur.name, mon_idx, mon_bad);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok %s: %0d", name, act);
        end
    endtask

    task automatic drive(int s, logic v, logic [7:0] d);
        case (s)
            0: begin if0.valid = v; if0.data_in = d; end
            1: begin if1.valid = v; if1.data_in = d; end
            2: begin if2.valid = v; if2.data_in = d; end
            default: begin if3.valid = v; if3.data_in = d[6:0]; end
        endcase
    endtask

    task automatic expect_frame(string bits, string name, bit may_abort);
        exp_t e;
        e.bits = bits;
        e.name = name;
        e.may_abort = may_abort;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(int s);
        int n = 0;
        while (!ready_of(s) && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 1000) check("ready_timeout", 0, 1);
    endtask

    task automatic send(int s, logic [7:0] d, output int acc_cyc);
        @(negedge clk); #1;
        wait_ready(s);
        drive(s, 1'b1, d);
        @(posedge clk); #1;
        acc_cyc = cyc;
        @(negedge clk); #1;
        drive(s, 1'b0, d);
    endtask

    task automatic wait_done(int s);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active || busy_of(s)) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 3000) check("frame_timeout", 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int d0;
        int b0;
        int n;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 8'h00);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_tx", int'(tx0), 1);
        check("reset_ready", int'(if0.ready), 1);
        check("reset_busy", int'(busy0), 0);
        check("reset_done", int'(done0), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("idle_after_tick_busy", int'(busy0), 0);
        check("idle_after_tick_tx", int'(tx0), 1);

        // 0xA5, defaults
        sel = 0;
        expect_frame("0101001011", "A5", 1'b0);
        d0 = done_seen;
        b0 = busy_cycles;
        send(0, 8'hA5, acc);
        wait_done(0);
        check("A5_done_pulses", done_seen - d0, 1);
        check("A5_busy_cycles", busy_cycles - b0, 160);
        check("A5_done_timing", done_cyc - start_q[$], 160);

        // Accept on a tick edge while idle: start waits a full interval
        n = 0;
        @(negedge clk); #1;
        while (!tick && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        expect_frame("0010110101", "5A_tick_accept", 1'b0);
        drive(0, 1'b1, 8'h5A);
        @(posedge clk); #1;
        acc = cyc;
        check("tick_accept_ready_low", int'(if0.ready), 0);
        @(negedge clk); #1;
        drive(0, 1'b0, 8'h00);
        wait_done(0);
        check("tick_accept_start_delay", start_q[$] - acc, 16);

        // Back-to-back with valid held high
        expect_frame("0001111001", "3C", 1'b0);
        expect_frame("0110000111", "C3", 1'b0);
        d0 = done_seen;
        @(negedge clk); #1;
        wait_ready(0);
        drive(0, 1'b1, 8'h3C);
        @(posedge clk); #1;
        drive(0, 1'b1, 8'hC3);
        check("b2b_ready_drops", int'(if0.ready), 0);
        @(negedge clk); #1;
        wait_ready(0);
        check("b2b_ready_at_start_tx", int'(tx0), 0);
        check("b2b_ready_at_start_busy", int'(busy0), 1);
        @(posedge clk); #1;
        check("b2b_second_accepted", int'(if0.ready), 0);
        drive(0, 1'b0, 8'h00);
        wait_done(0);
        check("b2b_done_pulses", done_seen - d0, 2);
        check("b2b_start_spacing", start_q[$] - start_q[$-1], 160);

        // Reset during DATA bit 3 with a second word held
        expect_frame("0000011111", "F0_aborted", 1'b1);
        send(0, 8'hF0, acc);
        n = 0;
        while (!mon_active && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) check("abort_start_timeout", 0, 1);
        drive(0, 1'b1, 8'h0F);
        @(negedge clk); #1;
        drive(0, 1'b0, 8'h00);
        repeat (71) @(negedge clk);
        #1;
        check("pre_reset_busy", int'(busy0), 1);
        check("pre_reset_ready", int'(if0.ready), 0);
        rst = 1'b1;
        #1;
        check("async_reset_tx", int'(tx0), 1);
        check("async_reset_busy", int'(busy0), 0);
        check("async_reset_ready", int'(if0.ready), 1);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("post_reset_idle", int'(busy0), 0);
        expect_frame("0100000011", "81", 1'b0);
        send(0, 8'h81, acc);
        wait_done(0);

        // Parity variants
        sel = 1;
        expect_frame("01110000011", "07_even", 1'b0);
        send(1, 8'h07, acc);
        wait_done(1);
        sel = 2;
        expect_frame("01110000001", "07_odd", 1'b0);
        expect_frame("00000000011", "00_odd", 1'b0);
        send(2, 8'h07, acc);
        send(2, 8'h00, acc);
        wait_done(2);

        // 7 data bits, 2 stop bits
        sel = 3;
        expect_frame("0101010111", "55_7d2s", 1'b0);
        d0 = done_seen;
        send(3, 8'h55, acc);
        wait_done(3);
        check("7d2s_done_pulses", done_seen - d0, 1);
        check("7d2s_done_after_2nd_stop", done_cyc - start_q[$], 160);

        repeat (40) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
